serial_add_unit: RTL and testbench

Bit-serial WIDTH-bit add/subtract unit built around the team's 1-bit `adder` cell (inA, inB, cin, y). It is the consumer stage of that cell: it feeds one operand bit pair plus the registered carry into the cell each cycle and shifts the sum bit into a result register. It provides the area-minimal ALU add/sub path for the multicycle MIPS datapath and is controlled by a start/busy/done handshake.

---
 rtl/serial_add_unit.sv | 120 ++++++++++++
 tb/tb_serial_add_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit add/subtract unit for the multicycle MIPS ALU path.
// One operand bit pair per cycle runs through the 1-bit adder cell, and the
// unit uses a start/busy/done handshake.

module adder (
  input  logic inA,
  input  logic inB,
  input  logic cin,
  output logic y
);
  assign y = inA ^ inB ^ cin;
endmodule

module serial_add_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_PREV = CNT_W'(WIDTH - 2);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_carry;
  logic             r_carryMsb;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  logic             w_sum;
  logic             w_carryNext;
  logic [WIDTH-1:0] w_resultNext;
  logic             w_accept;

  adder u_adder (
    .inA (r_opA[0]),
    .inB (r_opB[0]),
    .cin (r_carry),
    .y   (w_sum)
  );

  // The cell exposes only the sum, so the carry is regenerated here.
  assign w_carryNext  = (r_opA[0] & r_opB[0]) | (r_opA[0] & r_carry) | (r_opB[0] & r_carry);
  assign w_resultNext = {w_sum, r_result[WIDTH-1:1]};
  assign w_accept     = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_carry    <= 1'b0;
      r_carryMsb <= 1'b0;
      r_count    <= '0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_opA    <= {1'b0, r_opA[WIDTH-1:1]};
          r_opB    <= {1'b0, r_opB[WIDTH-1:1]};
          r_carry  <= w_carryNext;
          r_result <= w_resultNext;
          r_count  <= r_count + 1'b1;
          if (r_count == MSB_PREV) begin
            r_carryMsb <= w_carryNext;
          end
          if (r_count == LAST_BIT) begin
            r_state    <= S_DONE;
            r_cout     <= w_carryNext;
            r_overflow <= r_carryMsb ^ w_carryNext;
            r_zero     <= (w_resultNext == '0);
          end
        end
        default: begin
          // Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
          if (w_accept) begin
            r_opA   <= a;
            r_opB   <= sub ? ~b : b;
            r_carry <= sub;
            r_count <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed-vector self-checking bench for serial_add_unit (WIDTH=32).
// Expected values are hand-computed constants.

module tb_serial_add_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  int compared   = 0;
  int mismatched = 0;
  int nEdges;
  int busyCnt;
  int doneSeen;

  serial_add_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Leaves the bench at the negedge right after the accepting edge E0.
  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input logic isSub);
    @(negedge clk);
    a = opA; b = opB; sub = isSub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after E0 until done; optionally injects a start at edge intrudeAt+1.
  task automatic waitDone(input string tag, input int intrudeAt, output int n, output int bCnt);
    n = 0; bCnt = 0;
    while (!done && n < 100) begin
      if (busy) bCnt++;
      if (n == intrudeAt) begin
        start = 1'b1; a = 32'd100; b = 32'd100; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput({tag, ".latency"}, n, 32);
  endtask

  task automatic checkResult(input string tag, input logic [31:0] expRes, input logic expCout,
                             input logic expOvf, input logic expZero);
    checkOutput({tag, ".done"},     {31'd0, done},     32'd1);
    checkOutput({tag, ".result"},   result,            expRes);
    checkOutput({tag, ".cout"},     {31'd0, cout},     {31'd0, expCout});
    checkOutput({tag, ".overflow"}, {31'd0, overflow}, {31'd0, expOvf});
    checkOutput({tag, ".zero"},     {31'd0, zero},     {31'd0, expZero});
  endtask

  task automatic runOp(input string tag, input logic [31:0] opA, input logic [31:0] opB, input logic isSub,
                       input logic [31:0] expRes, input logic expCout, input logic expOvf, input logic expZero);
    applyStimulus(opA, opB, isSub);
    waitDone(tag, -1, nEdges, busyCnt);
    checkOutput({tag, ".busyCycles"}, busyCnt, 32);
    checkResult(tag, expRes, expCout, expOvf, expZero);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".idleBusy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy",  {31'd0, busy}, 32'd0);
    checkOutput("reset.done",  {31'd0, done}, 32'd0);
    checkOutput("reset.result", result, 32'd0);
    checkOutput("reset.flags", {29'd0, cout, overflow, zero}, 32'd0);
    rst = 1'b1;

    runOp("add5p3",   32'd5,          32'd3, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    runOp("sub5m7",   32'd5,          32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    runOp("sub7m7",   32'd7,          32'd7, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    runOp("ovfPos",   32'h7FFF_FFFF,  32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    runOp("wrapZero", 32'hFFFF_FFFF,  32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("idleHold.result", result, 32'h0000_0000);
    checkOutput("idleHold.zero", {31'd0, zero}, 32'd1);

    // start during RUN must be ignored
    applyStimulus(32'd1, 32'd1, 1'b0);
    waitDone("intrude", 9, nEdges, busyCnt);
    checkResult("intrude", 32'd2, 1'b0, 1'b0, 1'b0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("intrude.noSecondDone", doneSeen, 0);

    // reset mid-RUN: rst sampled low at edge 15
    applyStimulus(32'd9, 32'd9, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
    checkOutput("midReset.done", {31'd0, done}, 32'd0);
    checkOutput("midReset.result", result, 32'd0);
    rst = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("midReset.noDone", doneSeen, 0);
    runOp("afterReset", 32'd9, 32'd9, 1'b0, 32'd18, 1'b0, 1'b0, 1'b0);

    // back-to-back: start held in the DONE cycle
    applyStimulus(32'd20, 32'd3, 1'b0);
    waitDone("b2bFirst", -1, nEdges, busyCnt);
    checkResult("b2bFirst", 32'd23, 1'b0, 1'b0, 1'b0);
    checkOutput("b2bFirst.busyInDone", {31'd0, busy}, 32'd0);
    a = 32'd10; b = 32'd4; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b.busyResumed", {31'd0, busy}, 32'd1);
    checkOutput("b2b.doneLow", {31'd0, done}, 32'd0);
    waitDone("b2bSecond", -1, nEdges, busyCnt);
    checkOutput("b2bSecond.busyCycles", busyCnt, 32);
    checkResult("b2bSecond", 32'd6, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
